// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns and BCD digit step helpers
package seg_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {carry, digit}; cin=0 passes the digit through untouched
  function automatic logic [BCD_DIGIT_W:0] bcd_inc(input logic [BCD_DIGIT_W-1:0] d,
                                                   input logic cin);
    if (!cin)
      return {1'b0, d};
    if (d >= 4'd9)
      return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // Returns {borrow, digit}
  function automatic logic [BCD_DIGIT_W:0] bcd_dec(input logic [BCD_DIGIT_W-1:0] d,
                                                   input logic bin);
    if (!bin)
      return {1'b0, d};
    if (d == 4'd0)
      return {1'b1, 4'd9};
    return {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 4-bit code to active-low seven-segment pattern
module seg7_decoder
  import seg_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] code,
  output logic [6:0]             pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_auto_counter.sv
// rtl/seg_auto_counter.sv - BCD up/down tick counter with multiplexed seven-segment scan
module seg_auto_counter
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int SCAN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          en,
  input  logic                          up,
  input  logic                          clear,
  output logic [BCD_DIGIT_W*DIGITS-1:0] value,
  output logic                          wrap,
  output logic [DIGITS-1:0]             an,
  output logic [6:0]                    seg,
  output logic                          dp
);

  localparam int                    IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_WIDTH-1:0] SCAN_LAST = SCAN_WIDTH'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [BCD_DIGIT_W*DIGITS-1:0] value_step;
  logic                          ripple;
  logic [BCD_DIGIT_W:0]          digit_res;
  logic [SCAN_WIDTH-1:0]         scan_cnt;
  logic [IDX_W-1:0]              idx;
  logic [BCD_DIGIT_W-1:0]        cur_digit;
  logic [DIGITS-1:0]             an_next;
  logic [6:0]                    seg_next;

  // Ripple carry/borrow enters at digit 0; what leaves the top digit is the wrap
  always_comb begin
    value_step = value;
    ripple     = 1'b1;
    digit_res  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_res = up ? bcd_inc(value[i*BCD_DIGIT_W +: BCD_DIGIT_W], ripple)
                     : bcd_dec(value[i*BCD_DIGIT_W +: BCD_DIGIT_W], ripple);
      value_step[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_res[BCD_DIGIT_W-1:0];
      ripple = digit_res[BCD_DIGIT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (tick && en) begin
      value <= value_step;
      wrap  <= ripple;
    end else begin
      wrap  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_digit = '0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_digit  = value[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        an_next[i] = 1'b0;
      end
    end
  end

  seg7_decoder u_dec (
    .code    (cur_digit),
    .pattern (seg_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: doc/seg_auto_counter.md
Name: seg_auto_counter

Overview:
Downstream consumer of the periodic tick generator in the segment_auto design. Counts incoming one-cycle tick pulses as a DIGITS-wide BCD up/down counter. Time-multiplexes the count onto a common-anode seven-segment display with an internal scan prescaler. Exposes the raw BCD value and a wrap flag for other logic.

Parameters:
DIGITS, 4, number of BCD digits and anode lines (2..8).
SCAN_DIV, 50000, clock cycles each digit stays lit; must be >= 2.
SCAN_WIDTH, 16, width of the scan prescaler; must hold SCAN_DIV-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
tick  input  1  single-cycle count strobe from the tick generator.
en  input  1  count enable; tick is ignored while low.
up  input  1  direction: 1 = increment, 0 = decrement.
clear  input  1  synchronous clear of the count.
value  output  4*DIGITS  current BCD count; digit 0 in bits [3:0].
wrap  output  1  one-cycle pulse on 9..9->0..0 (up) or 0..0->9..9 (down).
an  output  DIGITS  anode enables, active-low, one-hot-zero.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low; held at 1 (off).

Behaviour:
- Reset (rst=0, asynchronous): value=0, wrap=0, scan prescaler=0, digit index=0, an=all 1s, seg=7'h7F, dp=1. Reset takes effect immediately, including mid-count or mid-scan.
- Count priority, evaluated each cycle:
  - clear: value<=0, wrap<=0. Clear wins over a simultaneous tick.
  - Else tick&en&up: BCD increment with ripple carry. A digit at 9 becomes 0 and carries into the next digit.
  - Else tick&en&~up: BCD decrement with ripple borrow. A digit at 0 becomes 9 and borrows from the next digit.
  - Else: hold.
- Latency: value and wrap update on the edge where tick is sampled high, so they are visible the next cycle.
- wrap: high for exactly one cycle when an increment from all-9s or a decrement from all-0s occurs; low otherwise.
- Back-to-back ticks (tick high on consecutive cycles) count once per cycle with no loss.
- value always holds valid BCD (0..9 per digit).
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 whenever not in reset.
  - At SCAN_DIV-1 it returns to 0 and the digit index advances modulo DIGITS (DIGITS-1 -> 0).
- Display outputs are registered from the current index and value, with one cycle of latency:
  - an[index]=0, all other anodes 1.
  - seg = decode(value digit[index]).
  - First cycle after reset release: an=...1110, seg shows digit 0.
- A count change while a digit is lit appears on seg the following cycle; no blanking between digits is required.
- Segment patterns (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10..15 give blank (1111111).

Decomposition:
- Shared package seg_pkg:
  - SEG_0..SEG_9 pattern constants and SEG_BLANK.
  - BCD_DIGIT_W=4.
  - Function bcd_inc/bcd_dec returning {carry, digit}.
- One sub-module, seg7_decoder: combinational 4-bit code to 7-bit active-low pattern. It is instantiated once on the muxed digit.
- BCD counter and scan logic live in seg_auto_counter.

Test Plan:
1. rst=0 mid-count with value=0123 -> immediately value=0, an=1111, seg=7F. After release, next cycle an=1110, seg=1000000.
2. Preload value=0009 via 9 ticks, up=1, en=1, one more tick -> value=0010 next cycle, wrap=0.
3. value=9999, up=1, tick -> value=0000, wrap=1 for exactly one cycle. Then value=0000, up=0, tick -> value=9999, wrap=1.
4. tick and clear in the same cycle with value=0042 -> value=0000, wrap=0. tick with en=0 -> value unchanged.
5. SCAN_DIV=4, value=1234 -> anodes rotate 1110,1101,1011,0111 every 4 cycles. Corresponding seg patterns are 0011001 (digit 0 = 4), 0110000 (3), 0100100 (2), 1111001 (1). The rotation then wraps back to 1110.
6. tick held high for 15 consecutive cycles from value=0000, up=1 -> value=0015, no wrap.
